axis_pulsegen_v3: RTL
=====================

# axis_pulsegen_v3

Parametrised successor to the fixed 16-sample pulse generator.
- Replays an N-sample-per-beat waveform of up to 2^L beats from an internal memory onto an AXI4-Stream output.
- Supports repetition count, programmable inter-repetition gap, continuous mode, abort, and `m_axis_tready` backpressure.
- Sits between the configuration slave (register and memory writes, same clock) and the DAC/stream fabric.

## Interface
Parameters:
- N, 16, samples per beat.
- B, 16, bits per sample.
- L, 4, log2 of waveform memory depth in beats (16 beats).

Ports (one clock; reset is asynchronous and active-low):
- aclk  in  1  clock for all logic.
- aresetn  in  1  asynchronous active-low reset.
- start  in  1  external trigger, synchronous to aclk.
- mem_we  in  1  waveform memory write enable.
- mem_addr  in  L  beat address to write.
- mem_wdata  in  N*B  beat data; sample k at bits [k*B +: B].
- START_REG  in  1  software trigger.
- START_SRC_REG  in  1  trigger select: 0 = START_REG, 1 = start.
- MODE_REG  in  1  0 = burst, 1 = continuous.
- LEN_REG  in  L+1  beats per repetition (0..2^L).
- NREP_REG  in  16  repetitions in burst mode; 0 is treated as 1.
- WAIT_REG  in  32  idle cycles between repetitions.
- STOP_REG  in  1  abort request (level).
- m_axis_tready  in  1  downstream ready.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tdata  out  N*B  beat data.
- busy  out  1  high when not IDLE.
- done  out  1  one-cycle pulse at normal burst completion.

## Operation
- Memory: 2^L x N*B array.
  - Write on mem_we at any time, including during playback; takes effect on the next read of that address.
  - Read is combinational into the output register.
- Trigger: rising edge of the selected source, found by comparing against a registered previous value (previous value resets to 0). Both sources are edge-detected every cycle.
- Latch on trigger: LEN, NREP, WAIT and MODE are latched at the accepted trigger. Register changes during playback have no effect.
- States: IDLE, PLAY, GAP.
- IDLE:
  - Trigger with latched LEN != 0 -> PLAY; beat address = 0, repetition count = 0.
  - Trigger with LEN = 0 is ignored.
  - Triggers outside IDLE are ignored.
- PLAY:
  - When (!tvalid || tready): load tdata = mem[addr], set tvalid = 1, addr++.
  - After the beat at addr = LEN-1 is loaded, repetition count++.
  - When the last beat of a repetition is accepted:
    - Burst mode, count = NREP -> IDLE, pulse done.
    - Otherwise, WAIT = 0 -> next beat is addr 0 with no bubble.
    - Otherwise, WAIT > 0 -> GAP.
- GAP: tvalid = 0; counts exactly WAIT cycles, then PLAY from addr 0.
- Continuous mode: repeats indefinitely; NREP is ignored; done never pulses.
- Abort: STOP_REG high in PLAY or GAP.
  - Any beat already presented with tvalid is held until accepted; no new beat is loaded.
  - Then -> IDLE. No done pulse.
  - STOP_REG held high in IDLE does not block triggers; it aborts immediately after entry to PLAY.
- tdata is zeroed whenever tvalid is 0. tvalid never drops while tready is 0.
- Counters: repetition count 16 bits; gap counter 32 bits; beat address wraps naturally at LEN = 2^L.

## Timing
- Reset values: tvalid = 0, tdata = 0, busy = 0, done = 0, state IDLE, all counters 0.
- Reset mid-playback clears the output on assertion; no beat completes.
- Trigger latency: let the selected source be first sampled high at edge t.
  - State = PLAY after edge t.
  - First beat tvalid = 1 after edge t+1.
- busy: rises with PLAY (after edge t); falls on the cycle the state returns to IDLE.
- done: high for the single cycle following acceptance of the final beat, coincident with the tvalid = 0 cycle.
- Throughput: 1 beat/cycle with tready = 1.
- Gap length: exactly WAIT cycles of tvalid = 0 between the last beat of one repetition and the first of the next.
- Simultaneous events:
  - Trigger and STOP in IDLE in the same cycle -> PLAY entered, then abort next cycle; no beat is emitted.
  - mem_we to the address being read in the same cycle -> the old data is emitted.

## Test plan
- Burst, no gap: LEN = 4, NREP = 2, WAIT = 0, tready = 1, beat k = k+1, software trigger -> beats 1,2,3,4,1,2,3,4 on 8 consecutive cycles starting 2 cycles after the trigger; done pulses once; busy high 9 cycles.
- Gap: LEN = 2, NREP = 3, WAIT = 5 -> pattern 2 valid, 5 invalid, 2 valid, 5 invalid, 2 valid; tdata = 0 during gaps.
- Backpressure: LEN = 3, tready toggled 1,0,0,1,1 -> each beat is held stable while tready = 0; all 3 beats delivered in order, none duplicated.
- Continuous and abort: MODE = 1, LEN = 2, WAIT = 0 -> alternating beats for 20 cycles. STOP raised with tready = 0 -> the held beat completes on the tready edge, then tvalid = 0, busy = 0, no done.
- Trigger handling:
  - START_SRC = 1: start held high 10 cycles -> exactly one playback.
  - Trigger during PLAY -> ignored.
  - LEN = 0 -> no output, busy stays 0.
  - NREP = 0 -> one repetition.
- Reset: aresetn asserted mid-PLAY -> tvalid and tdata go to 0 immediately. A trigger after release replays from addr 0.

Source files
------------

// File: rtl/axis_pulsegen_v3.sv
// axis_pulsegen_v3: replays an N-sample-per-beat waveform of up to 2^L beats
// from internal memory onto an AXI4-Stream master port. The waveform can be
// repeated a set number of times with an optional idle gap between
// repetitions, or looped until an abort is requested. Downstream
// backpressure is honoured on every beat.
module axis_pulsegen_v3 #(
  parameter int N = 16,  // samples per beat
  parameter int B = 16,  // bits per sample
  parameter int L = 4    // log2 of waveform depth in beats
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             start,
  input  logic             mem_we,
  input  logic [L-1:0]     mem_addr,
  input  logic [N*B-1:0]   mem_wdata,
  input  logic             START_REG,
  input  logic             START_SRC_REG,
  input  logic             MODE_REG,
  input  logic [L:0]       LEN_REG,
  input  logic [15:0]      NREP_REG,
  input  logic [31:0]      WAIT_REG,
  input  logic             STOP_REG,
  input  logic             m_axis_tready,
  output logic             m_axis_tvalid,
  output logic [N*B-1:0]   m_axis_tdata,
  output logic             busy,
  output logic             done
);

  localparam int W     = N * B;
  localparam int DEPTH = 2 ** L;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_GAP
  } state_t;

  // Waveform memory, one full beat per word.
  logic [W-1:0] mem_q [DEPTH];

  // Registered state.
  state_t       state_q,   state_d;
  logic [L-1:0] addr_q,    addr_d;     // next beat address to load
  logic         last_q,    last_d;     // presented beat ends a repetition
  logic [15:0]  rep_q,     rep_d;      // repetitions fully loaded so far
  logic [31:0]  gap_cnt_q, gap_cnt_d;  // idle cycles elapsed in GAP
  logic [L:0]   len_q,     len_d;      // latched beats per repetition
  logic [15:0]  nrep_q,    nrep_d;     // latched repetitions (0 mapped to 1)
  logic [31:0]  wait_q,    wait_d;     // latched gap length
  logic         mode_q,    mode_d;     // latched mode, 1 = continuous
  logic         tvalid_q,  tvalid_d;
  logic [W-1:0] tdata_q,   tdata_d;
  logic         busy_q,    busy_d;
  logic         done_q,    done_d;
  logic         sw_prev_q, ext_prev_q; // previous trigger levels

  // Combinational helpers.
  logic         sw_rise;
  logic         ext_rise;
  logic         trig;
  logic         accept;
  logic         load_beat;
  logic [L-1:0] rd_addr;
  logic [W-1:0] mem_rdata;
  logic         rd_is_last;

  assign sw_rise   = START_REG & ~sw_prev_q;
  assign ext_rise  = start & ~ext_prev_q;
  assign trig      = START_SRC_REG ? ext_rise : sw_rise;
  assign accept    = tvalid_q & m_axis_tready;
  assign mem_rdata = mem_q[rd_addr];
  // The beat about to be loaded closes the repetition when it sits at LEN-1.
  assign rd_is_last = ({1'b0, rd_addr} == (len_q - (L+1)'(1)));

  // Waveform memory write port; a same-cycle read still sees the old word.
  // NOTE: the memory is deliberately left out of reset; clearing a RAM array
  // on reset prevents it from mapping onto RAM primitives and serves no purpose
  // because software always loads the waveform before triggering.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end
  end

  // Next-state logic for the playback FSM, counters and output register.
  always_comb begin
    // NOTE: every variable assigned in this block gets a default first, so no
    // path through the case statement can leave one unassigned and infer a latch.
    state_d   = state_q;
    addr_d    = addr_q;
    last_d    = last_q;
    rep_d     = rep_q;
    gap_cnt_d = gap_cnt_q;
    len_d     = len_q;
    nrep_d    = nrep_q;
    wait_d    = wait_q;
    mode_d    = mode_q;
    tvalid_d  = tvalid_q;
    tdata_d   = tdata_q;
    done_d    = 1'b0;
    load_beat = 1'b0;
    rd_addr   = addr_q;

    unique case (state_q)
      S_IDLE: begin
        // A zero-length waveform is not a playable request.
        if (trig && (LEN_REG != '0)) begin
          state_d   = S_PLAY;
          len_d     = LEN_REG;
          nrep_d    = (NREP_REG == 16'd0) ? 16'd1 : NREP_REG;
          wait_d    = WAIT_REG;
          mode_d    = MODE_REG;
          addr_d    = '0;
          last_d    = 1'b0;
          rep_d     = 16'd0;
          gap_cnt_d = 32'd0;
        end
      end

      S_PLAY: begin
        if (STOP_REG) begin
          // Abort: a presented beat must still be taken before leaving.
          if (!tvalid_q || m_axis_tready) begin
            state_d  = S_IDLE;
            tvalid_d = 1'b0;
          end
        end else if (accept && last_q) begin
          if (!mode_q && (rep_q == nrep_q)) begin
            state_d  = S_IDLE;
            tvalid_d = 1'b0;
            done_d   = 1'b1;
          end else if (wait_q == 32'd0) begin
            // Back-to-back repetition: restart at beat 0 without a bubble.
            load_beat = 1'b1;
            rd_addr   = '0;
          end else begin
            state_d   = S_GAP;
            tvalid_d  = 1'b0;
            gap_cnt_d = 32'd1;
          end
        end else if (!tvalid_q || m_axis_tready) begin
          load_beat = 1'b1;
        end
      end

      S_GAP: begin
        if (STOP_REG) begin
          state_d = S_IDLE;
        end else if (gap_cnt_q == wait_q) begin
          // Load beat 0 on the final gap edge so exactly WAIT idle cycles show.
          state_d   = S_PLAY;
          load_beat = 1'b1;
          rd_addr   = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 32'd1;
        end
      end

      default: begin
        state_d  = S_IDLE;
        tvalid_d = 1'b0;
      end
    endcase

    if (load_beat) begin
      tdata_d  = mem_rdata;
      tvalid_d = 1'b1;
      addr_d   = rd_addr + L'(1);
      last_d   = rd_is_last;
      if (rd_is_last) begin
        rep_d = rep_q + 16'd1;
      end
    end

    // The data bus is quiet whenever no beat is offered.
    if (!tvalid_d) begin
      tdata_d = '0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State register for the FSM, counters, outputs and trigger history.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      last_q     <= 1'b0;
      rep_q      <= 16'd0;
      gap_cnt_q  <= 32'd0;
      len_q      <= '0;
      nrep_q     <= 16'd0;
      wait_q     <= 32'd0;
      mode_q     <= 1'b0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sw_prev_q  <= 1'b0;
      ext_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      last_q     <= last_d;
      rep_q      <= rep_d;
      gap_cnt_q  <= gap_cnt_d;
      len_q      <= len_d;
      nrep_q     <= nrep_d;
      wait_q     <= wait_d;
      mode_q     <= mode_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sw_prev_q  <= START_REG;
      ext_prev_q <= start;
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
